// File: rtl/fft_bf_sequencer.sv
// fft_bf_sequencer: control sequencer for a 32-point radix-2 DIT FFT butterfly/MAC stage.
// Walks 5 stages x 16 butterflies, issues operand read addresses and twiddle index,
// produces the 4-phase MAC sequence (count, count_reg, flag) and a delayed write strobe.
// Optional build macro: FFT_STALL_EN adds a 'hold' input that freezes the whole sequencer.
module fft_bf_sequencer #(
  parameter int WB_LAT = 2,
  parameter int N_LOG2 = 5
) (
  input  logic       clk_MAC,
  input  logic       rst,
`ifdef FFT_STALL_EN
  input  logic       hold,
`endif
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] stage,
  output logic [4:0] addr_a,
  output logic [4:0] addr_b,
  output logic [3:0] tw_idx,
  output logic [2:0] count,
  output logic [2:0] count_reg,
  output logic       flag,
  output logic       wr_en,
  output logic [4:0] wr_addr_a,
  output logic [4:0] wr_addr_b
);

  localparam logic [2:0] LAST_STAGE = 3'(N_LOG2 - 1);
  localparam logic [3:0] LAST_BFLY  = 4'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(WB_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state_r;
  logic [2:0] stage_r;
  logic [3:0] bfly_r;
  logic [1:0] count_r;
  logic [1:0] count_reg_r;
  logic [2:0] drain_cnt_r;
  logic       flag_r;
  logic       busy_r;
  logic       done_r;
  logic [4:0] flag_addr_a_r;
  logic [4:0] flag_addr_b_r;

  logic [WB_LAT-1:0] pipe_en_r;
  logic [4:0]        pipe_a_r [WB_LAT];
  logic [4:0]        pipe_b_r [WB_LAT];

  logic       freeze_s;
  logic [4:0] span_s;
  logic [4:0] pos_s;
  logic [4:0] grp_s;
  logic [4:0] addr_a_s;
  logic [4:0] addr_b_s;
  logic [3:0] tw_s;

`ifdef FFT_STALL_EN
  assign freeze_s = hold;
`else
  assign freeze_s = 1'b0;
`endif

  // Butterfly address and twiddle arithmetic from the registered stage/bfly;
  // forced to zero outside RUN/DRAIN so the idle block presents all-zero outputs.
  always_comb begin
    span_s   = 5'd1 << stage_r;
    pos_s    = {1'b0, bfly_r} & (span_s - 5'd1);
    grp_s    = {1'b0, bfly_r} >> stage_r;
    addr_a_s = 5'd0;
    addr_b_s = 5'd0;
    tw_s     = 4'd0;
    if (busy_r) begin
      addr_a_s = (grp_s << (stage_r + 3'd1)) + pos_s;
      addr_b_s = addr_a_s + span_s;
      tw_s     = pos_s[3:0] << (LAST_STAGE - stage_r);
    end else begin
      addr_a_s = 5'd0;
      addr_b_s = 5'd0;
      tw_s     = 4'd0;
    end
  end

  // Main sequencer FSM: stage/butterfly/phase counters, drain timer and status flags.
  always_ff @(posedge clk_MAC or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      stage_r       <= 3'd0;
      bfly_r        <= 4'd0;
      count_r       <= 2'd0;
      count_reg_r   <= 2'd0;
      drain_cnt_r   <= 3'd0;
      flag_r        <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      flag_addr_a_r <= 5'd0;
      flag_addr_b_r <= 5'd0;
    end else if (!freeze_s) begin
      count_reg_r   <= count_r;
      flag_r        <= (state_r == ST_RUN) && (count_r == 2'd3);
      flag_addr_a_r <= addr_a_s;
      flag_addr_b_r <= addr_b_s;
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_RUN;
            stage_r <= 3'd0;
            bfly_r  <= 4'd0;
            count_r <= 2'd0;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          count_r <= count_r + 2'd1;
          if (count_r == 2'd3) begin
            bfly_r <= bfly_r + 4'd1;
            if (bfly_r == LAST_BFLY) begin
              state_r     <= ST_DRAIN;
              drain_cnt_r <= 3'd0;
            end
          end
        end
        ST_DRAIN: begin
          // Drain covers the write-back latency so the next stage never reads stale data.
          count_r <= 2'd0;
          if (drain_cnt_r == DRAIN_LAST) begin
            drain_cnt_r <= 3'd0;
            bfly_r      <= 4'd0;
            if (stage_r < LAST_STAGE) begin
              stage_r <= stage_r + 3'd1;
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            drain_cnt_r <= drain_cnt_r + 3'd1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          stage_r <= 3'd0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          stage_r <= 3'd0;
          bfly_r  <= 4'd0;
          count_r <= 2'd0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Write-back delay line: carries flag and its butterfly's addresses WB_LAT cycles.
  always_ff @(posedge clk_MAC or negedge rst) begin
    if (!rst) begin
      pipe_en_r <= '0;
      for (int i = 0; i < WB_LAT; i++) begin
        pipe_a_r[i] <= 5'd0;
        pipe_b_r[i] <= 5'd0;
      end
    end else if (!freeze_s) begin
      pipe_en_r[0] <= flag_r;
      pipe_a_r[0]  <= flag_addr_a_r;
      pipe_b_r[0]  <= flag_addr_b_r;
      for (int i = 1; i < WB_LAT; i++) begin
        pipe_en_r[i] <= pipe_en_r[i-1];
        pipe_a_r[i]  <= pipe_a_r[i-1];
        pipe_b_r[i]  <= pipe_b_r[i-1];
      end
    end
  end

  // Output mapping; strobes are masked while frozen so a pending write resumes on release.
  always_comb begin
    busy      = busy_r;
    stage     = stage_r;
    addr_a    = addr_a_s;
    addr_b    = addr_b_s;
    tw_idx    = tw_s;
    count     = {1'b0, count_r};
    count_reg = {1'b0, count_reg_r};
    flag      = flag_r;
    wr_addr_a = pipe_a_r[WB_LAT-1];
    wr_addr_b = pipe_b_r[WB_LAT-1];
    if (freeze_s) begin
      done  = 1'b0;
      wr_en = 1'b0;
    end else begin
      done  = done_r;
      wr_en = pipe_en_r[WB_LAT-1];
    end
  end

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Directed self-checking bench for fft_bf_sequencer (WB_LAT=2).
module tb_fft_bf_sequencer;

  logic       clk_MAC = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic [2:0] stage;
  logic [4:0] addr_a;
  logic [4:0] addr_b;
  logic [3:0] tw_idx;
  logic [2:0] count;
  logic [2:0] count_reg;
  logic       flag;
  logic       wr_en;
  logic [4:0] wr_addr_a;
  logic [4:0] wr_addr_b;
`ifdef FFT_STALL_EN
  logic       hold;
`endif

  int checks = 0;
  int errors = 0;

  fft_bf_sequencer #(.WB_LAT(2), .N_LOG2(5)) dut (
    .clk_MAC   (clk_MAC),
    .rst       (rst),
`ifdef FFT_STALL_EN
    .hold      (hold),
`endif
    .start     (start),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .count     (count),
    .count_reg (count_reg),
    .flag      (flag),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  always #5 clk_MAC = ~clk_MAC;

  task automatic step();
    @(posedge clk_MAC);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int st, j, wr_cnt, done_cnt, done_k, saved;
    int e_count, e_creg, e_flag, e_wr, e_busy, e_done;

    // Reset then idle
    rst = 1'b0;
    start = 1'b0;
`ifdef FFT_STALL_EN
    hold = 1'b0;
`endif
    repeat (3) @(posedge clk_MAC);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr_b", 32'(addr_b), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_wr_en", 32'(wr_en), 32'd0);
      chk("idle_addr_a", 32'(addr_a), 32'd0);
      chk("idle_addr_b", 32'(addr_b), 32'd0);
      chk("idle_tw", 32'(tw_idx), 32'd0);
      chk("idle_flag", 32'(flag), 32'd0);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_stage", 32'(stage), 32'd0);
    end

    // Full transform; a start pulse while busy must be ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    wr_cnt = 0;
    done_cnt = 0;
    done_k = -1;
    for (int k = 1; k <= 345; k++) begin
      step();
      st = k / 67;
      j = k % 67;
      e_busy  = (k < 335) ? 1 : 0;
      e_count = (k < 335 && j < 64) ? (j % 4) : 0;
      e_creg  = (k < 335 && j >= 1 && j <= 64) ? ((j - 1) % 4) : 0;
      e_flag  = (k < 335 && j >= 4 && j <= 64 && (j % 4) == 0) ? 1 : 0;
      e_wr    = (k < 335 && j >= 6 && (j % 4) == 2) ? 1 : 0;
      e_done  = (k == 335) ? 1 : 0;
      chk("run_busy", 32'(busy), 32'(e_busy));
      chk("run_count", 32'(count), 32'(e_count));
      chk("run_count_reg", 32'(count_reg), 32'(e_creg));
      chk("run_flag", 32'(flag), 32'(e_flag));
      chk("run_wr_en", 32'(wr_en), 32'(e_wr));
      chk("run_done", 32'(done), 32'(e_done));
      if (k < 335) chk("run_stage", 32'(stage), 32'(st));
      if (e_wr == 1 && st == 0) begin
        chk("s0_wr_addr_a", 32'(wr_addr_a), 32'(2 * ((j - 6) / 4)));
        chk("s0_wr_addr_b", 32'(wr_addr_b), 32'(2 * ((j - 6) / 4) + 1));
      end
      if (k == 20) begin
        chk("s0b5_addr_a", 32'(addr_a), 32'd10);
        chk("s0b5_addr_b", 32'(addr_b), 32'd11);
        chk("s0b5_tw", 32'(tw_idx), 32'd0);
      end
      if (k == 66) begin
        chk("s0_last_wr_en", 32'(wr_en), 32'd1);
        chk("s0_last_wr_a", 32'(wr_addr_a), 32'd30);
        chk("s0_last_wr_b", 32'(wr_addr_b), 32'd31);
      end
      if (k == 67) begin
        chk("s1b0_addr_a", 32'(addr_a), 32'd0);
        chk("s1b0_addr_b", 32'(addr_b), 32'd2);
      end
      if (k == 154) begin
        chk("s2b5_addr_a", 32'(addr_a), 32'd9);
        chk("s2b5_addr_b", 32'(addr_b), 32'd13);
        chk("s2b5_tw", 32'(tw_idx), 32'd4);
      end
      if (k == 328) begin
        chk("s4b15_addr_a", 32'(addr_a), 32'd15);
        chk("s4b15_addr_b", 32'(addr_b), 32'd31);
        chk("s4b15_tw", 32'(tw_idx), 32'd15);
      end
      if (wr_en) wr_cnt++;
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (k == 100) start = 1'b1;
      if (k == 101) start = 1'b0;
    end
    chk("total_wr_en", 32'(wr_cnt), 32'd80);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_edge", 32'(done_k + 1), 32'd336);
    chk("busy_after", 32'(busy), 32'd0);

    // start held through DONE retriggers on the following edge
    start = 1'b1;
    step();
    chk("rt_busy_rise", 32'(busy), 32'd1);
    for (int k = 1; k <= 337; k++) begin
      step();
      if (k == 335) chk("rt_done", 32'(done), 32'd1);
      if (k == 336) begin
        chk("rt_idle_busy", 32'(busy), 32'd0);
        chk("rt_idle_done", 32'(done), 32'd0);
      end
      if (k == 337) begin
        chk("rt_restart_busy", 32'(busy), 32'd1);
        chk("rt_restart_stage", 32'(stage), 32'd0);
      end
    end
    start = 1'b0;

    // Asynchronous abort during stage 2
    repeat (150) step();
    chk("abort_pre_stage", 32'(stage), 32'd2);
    #3 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_stage", 32'(stage), 32'd0);
    chk("abort_addr_a", 32'(addr_a), 32'd0);
    chk("abort_addr_b", 32'(addr_b), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_count_reg", 32'(count_reg), 32'd0);
    chk("abort_flag", 32'(flag), 32'd0);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_wr_addr_a", 32'(wr_addr_a), 32'd0);
    step();
    step();
    rst = 1'b1;
    done_cnt = 0;
    repeat (400) begin
      step();
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);

`ifdef FFT_STALL_EN
    // Hold for 10 cycles in stage 1
    start = 1'b1;
    step();
    start = 1'b0;
    wr_cnt = 0;
    done_k = -1;
    saved = 0;
    for (int k = 1; k <= 360; k++) begin
      step();
      if (wr_en) wr_cnt++;
      if (done) done_k = k;
      if (k == 90) begin
        saved = int'(count);
        hold = 1'b1;
      end else if (k > 90 && k <= 100) begin
        chk("hold_count", 32'(count), 32'(saved));
        chk("hold_wr_en", 32'(wr_en), 32'd0);
        chk("hold_stage", 32'(stage), 32'd1);
        if (k == 100) hold = 1'b0;
      end
    end
    chk("hold_done_edge", 32'(done_k + 1), 32'd346);
    chk("hold_total_wr", 32'(wr_cnt), 32'd80);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bf_sequencer.md
Name: fft_bf_sequencer

Overview:
Control stage directly upstream of the butterfly/MAC datapath in the 32-point radix-2 DIT FFT. It walks 5 stages × 16 butterflies and generates per-butterfly A/B memory read addresses and the twiddle ROM index. It produces the 4-phase MAC sequence (count, count_reg, flag) that drives the butterfly muxes, then delays the addresses to form the result write-back strobe. The block is in-place and expects bit-reversed input ordering.

Parameters:
WB_LAT, 2, cycles from flag to result write strobe (butterfly output register depth); legal 1..7
N_LOG2, 5, log2 of FFT length; fixed at 5 for this design, other values unsupported

Ports:
clk_MAC  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a transform; sampled only in IDLE
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse on transform completion
stage  out  3  current stage 0..4
addr_a  out  5  read address of butterfly upper operand
addr_b  out  5  read address of butterfly lower operand
tw_idx  out  4  twiddle ROM index 0..15
count  out  3  MAC phase 0..3; bit 2 always 0
count_reg  out  3  count delayed one cycle
flag  out  1  high for the single cycle in which count_reg==3, while in RUN or DRAIN
wr_en  out  1  result write strobe
wr_addr_a  out  5  write address for OUT1 pair
wr_addr_b  out  5  write address for OUT2 pair

Behaviour:
- Reset (rst low, asynchronous): FSM=IDLE, all counters, pipelines and outputs 0. Reset mid-transform aborts it; no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 at an edge → RUN; stage=0, bfly=0, count=0.
- RUN: count increments 0→3 each cycle. On count==3, bfly increments. On bfly==15 && count==3 → DRAIN.
- DRAIN: lasts exactly WB_LAT+1 cycles, covering the read-after-write hazard. count holds 0.
  - At the end of DRAIN, if stage<4: stage+1, bfly=0 → RUN.
  - At the end of DRAIN, if stage==4: → DONE.
- DONE: done=1 for one cycle → IDLE. stage returns to 0.
- start is ignored outside IDLE.
- Address arithmetic, with s=stage, span=1<<s, pos=bfly&(span-1), grp=bfly>>s:
  - addr_a = (grp<<(s+1)) + pos
  - addr_b = addr_a + span
  - tw_idx = pos<<(4-s)
  - All three are combinational from the registered stage/bfly and held constant for the 4 phases of a butterfly.
- count_reg is registered from count. flag is a registered (count==3) qualified by RUN.
- wr_en/wr_addr_a/wr_addr_b: a shift pipeline WB_LAT deep, loaded with (flag, addr_a, addr_b) from the phase-3 cycle. wr_en asserts exactly WB_LAT cycles after flag.
- Totals:
  - 16 wr_en pulses per stage, 80 per transform.
  - done is high at the clock edge that comes exactly 5*(64+WB_LAT+1)+1 edges after the edge that sampled start (336 with WB_LAT=2).
- Boundary conditions:
  - The last wr_en of each stage falls in the final DRAIN cycle.
  - A start held high through DONE retriggers from IDLE on the following edge.

Optional Feature:
FFT_STALL_EN. When defined, an input port hold (1 bit) is added.
- While hold=1: FSM, stage/bfly/count, count_reg, flag and the write pipeline all freeze. wr_en is forced 0 while frozen and the pending strobe resumes on release.
- done is never emitted during hold.
- When undefined: no port is added and the block behaves as if hold=0.

Test Plan:
- Reset then idle: rst low 3 cycles, release, no start → all outputs 0, busy=0 for 20 cycles.
- Full transform, WB_LAT=2: start pulse → busy rises next cycle, 80 wr_en pulses, done exactly 336 edges after the start edge, then busy=0.
- Address check:
  - stage 0, bfly 5 → addr_a=10, addr_b=11, tw_idx=0.
  - stage 2, bfly 5 → addr_a=9, addr_b=13, tw_idx=4.
  - stage 4, bfly 15 → addr_a=15, addr_b=31, tw_idx=15.
- Phase/write alignment: per butterfly count 0,1,2,3, count_reg lagging 1. flag on count_reg==3. wr_en 2 cycles after flag, with wr_addr equal to that butterfly's addr_a/addr_b. The last stage-0 write occurs in the final DRAIN cycle, before stage 1's first read.
- Abort and ignore:
  - rst low at stage 2 → outputs 0 immediately (asynchronous), no done.
  - start pulsed while busy → ignored; done count stays 1.
- FFT_STALL_EN: hold=1 for 10 cycles mid-stage 1 → counters frozen, no wr_en during hold, done delayed by exactly 10 cycles (346).
